sample_uart_scheduler: RTL and testbench
========================================

// Module: sample_uart_scheduler
// PURPOSE
//  Sequences calibrated ADC samples (cal_in0..3, after input_cal) onto the uart_tx byte interface.
//  Takes a coherent snapshot of all channels on a decimated sample_clk rising edge.
//  Emits one frame per snapshot: for each enabled channel, 5 bytes 'C','H','0'+ch,MSB,LSB.
//  Replaces ad-hoc per-channel capture in top level; reports dropped snapshots (overruns).
// PARAMETERS
//  DECIM    1   frame tick every DECIM-th sample_clk rising edge (1..255)
//  OVF_W    8   width of saturating overrun counter
// PORTS
//  clk          in   1   system clock (12 MHz); sample_clk is generated in this domain
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = accept frame ticks; 0 = finish current frame, then idle
//  ch_mask      in   4   bit n=1 -> channel n included in frame; sampled at snapshot
//  sample_clk   in   1   sample strobe from ak4619; rising edge = new samples valid
//  cal_in0..3   in   16  signed calibrated samples, channels 0..3
//  tx_data      out  8   byte to uart_tx
//  tx_start     out  1   one-cycle issue strobe to uart_tx
//  tx_busy      in   1   uart_tx busy; asserted on the cycle after tx_start, low when idle
//  busy         out  1   1 while a frame is in progress (state != IDLE)
//  frame_done   out  1   one-cycle pulse after last byte of a frame completes
//  overruns     out  OVF_W  saturating count of frame ticks dropped while busy
// BEHAVIOUR
//  Reset: tx_data=0, tx_start=0, busy=0, frame_done=0, overruns=0, sc_q=0, div=0, state IDLE.
//  Edge detect: rise = sample_clk & ~sc_q; sc_q <= sample_clk every cycle.
//  div counts rises mod DECIM (wraps DECIM-1 -> 0); tick = rise & (div==0).
//  tick in IDLE with enable=1 and ch_mask!=0: latch cal_in0..3 and ch_mask into snap regs
//   same cycle; next cycle state SEL.
//  tick in IDLE with enable=0 or ch_mask==0: ignored, not counted.
//  tick while state!=IDLE: dropped, overruns += 1, saturates at all-ones; snapshot untouched.
//  States:
//   IDLE  wait tick.
//   SEL   ch = lowest set bit of remaining mask (ch>=cur); byte idx=0; -> ISSUE.
//   ISSUE if tx_busy==0: tx_data<=byte(idx), tx_start<=1 for exactly 1 cycle -> WBUSY;
//         else hold.
//   WBUSY wait tx_busy==1 -> WIDLE.
//   WIDLE wait tx_busy==0; idx<4: idx++ -> ISSUE; idx==4: clear ch bit;
//         mask empty -> DONE else -> SEL.
//   DONE  frame_done=1 one cycle -> IDLE.
//  Byte map: 0='C'(8'h43), 1='H'(8'h48), 2=8'h30+ch, 3=snap[ch][15:8], 4=snap[ch][7:0].
//  Channel order ascending; masked channels produce no bytes.
//  tx_data holds last issued byte between issues.
//  enable deassert mid-frame: frame completes; no new frame accepted.
//  enable only gates frame acceptance, never aborts.
//  ch_mask / cal_in changes mid-frame: no effect (snapshot).
//  Reset mid-frame: all state cleared immediately; partial frame abandoned;
//   tx_start forced 0.
//  Frame latency: tick -> first tx_start = 3 cycles (SEL, ISSUE registered); throughput bounded by uart.
// TESTING
//  1 mask=4'hF, cal_in0..3=16'h1234,16'hFFFF,16'h8000,16'h0001, stub uart (busy 10 cycles);
//    tick -> 20 bytes: 43 48 30 12 34 | 43 48 31 FF FF | 43 48 32 80 00 | 43 48 33 00 01;
//    then one frame_done pulse.
//  2 mask=4'b1010 -> 10 bytes with ch ids 8'h31,8'h33 only; mask=0 tick -> no tx_start,
//    overruns stays 0.
//  3 DECIM=4, 12 sample_clk rises while idle -> exactly 3 frames, on rises 1,5,9.
//  4 5 ticks during one frame -> overruns=5; OVF_W=2 with 6 drops -> overruns=3 (saturated).
//  5 change cal_in0 to 16'hAAAA after 2nd byte -> frame still sends original 12 34;
//    drop enable mid-frame -> frame finishes, next tick ignored.
//  6 assert rst_n=0 during WBUSY -> tx_start=0, busy=0, overruns=0; after release, next tick
//    restarts with 'C' for lowest enabled channel.

Source files
------------

// File: rtl/sample_uart_scheduler.sv
// Snapshots four calibrated ADC channels on a decimated sample_clk edge and
// streams one 5-byte record per enabled channel to a byte-wide UART transmitter.
//
// Handshake with uart_tx: tx_start is a one-cycle issue strobe. It is only
// raised while tx_busy is low. The transmitter then raises tx_busy on the next
// cycle and holds it until the byte has been sent. The next byte is issued only
// after tx_busy has been seen high and then low again.
module sample_uart_scheduler #(
  parameter int DECIM = 1,
  parameter int OVF_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [3:0]         ch_mask,
  input  logic               sample_clk,
  input  logic signed [15:0] cal_in0,
  input  logic signed [15:0] cal_in1,
  input  logic signed [15:0] cal_in2,
  input  logic signed [15:0] cal_in3,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               busy,
  output logic               frame_done,
  output logic [OVF_W-1:0]   overruns,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_ISSUE = 3'd2,
    S_WBUSY = 3'd3,
    S_WIDLE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  state_t      state, state_nx;
  logic        sc_q;
  logic [7:0]  div;
  logic [15:0] snap [4];
  logic [3:0]  rem;
  logic [1:0]  ch;
  logic [2:0]  idx;

  logic        rise, tick, accept;
  logic [1:0]  sel_ch;
  logic [3:0]  ch_bit;
  logic [7:0]  byte_val;

  assign rise   = sample_clk & ~sc_q;
  assign tick   = rise & (div == 8'd0);
  assign accept = tick & (state == S_IDLE) & enable & (|ch_mask);
  assign ch_bit = 4'b0001 << ch;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign state_dbg  = state;

  // Lowest remaining channel; cleared bits make this ascending order.
  always_comb begin
    sel_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rem[i]) sel_ch = 2'(i);
    end
  end

  always_comb begin
    byte_val = 8'h00;
    case (idx)
      3'd0:    byte_val = 8'h43;
      3'd1:    byte_val = 8'h48;
      3'd2:    byte_val = 8'h30 + {6'b0, ch};
      3'd3:    byte_val = snap[ch][15:8];
      3'd4:    byte_val = snap[ch][7:0];
      default: byte_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_SEL;
      S_SEL:   state_nx = S_ISSUE;
      S_ISSUE: if (!tx_busy) state_nx = S_WBUSY;
      S_WBUSY: if (tx_busy) state_nx = S_WIDLE;
      S_WIDLE: begin
        if (!tx_busy) begin
          if (idx != 3'd4)              state_nx = S_ISSUE;
          else if ((rem & ~ch_bit) == 4'b0) state_nx = S_DONE;
          else                          state_nx = S_SEL;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q     <= 1'b0;
      div      <= 8'd0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      overruns <= '0;
      rem      <= 4'b0;
      ch       <= 2'd0;
      idx      <= 3'd0;
      for (int i = 0; i < 4; i++) snap[i] <= 16'h0000;
    end else begin
      sc_q     <= sample_clk;
      tx_start <= 1'b0;
      if (rise) div <= (div == DECIM_LAST) ? 8'd0 : div + 8'd1;
      // A tick that arrives mid-frame is lost; count it, saturating.
      if (tick && (state != S_IDLE) && (overruns != {OVF_W{1'b1}}))
        overruns <= overruns + 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            snap[0] <= cal_in0;
            snap[1] <= cal_in1;
            snap[2] <= cal_in2;
            snap[3] <= cal_in3;
            rem     <= ch_mask;
          end
        end
        S_SEL: begin
          ch  <= sel_ch;
          idx <= 3'd0;
        end
        S_ISSUE: begin
          if (!tx_busy) begin
            tx_data  <= byte_val;
            tx_start <= 1'b1;
          end
        end
        S_WIDLE: begin
          if (!tx_busy) begin
            if (idx != 3'd4) idx <= idx + 3'd1;
            else             rem <= rem & ~ch_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_uart_scheduler.sv
// Bench for sample_uart_scheduler: scoreboard of expected UART bytes and
// frame_done markers, driven by randomized snapshots and directed corner cases.
module tb_sample_uart_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: DECIM=1, OVF_W=8
  logic        enable_a, sclk_a, tx_start_a, tx_busy_a, busy_a, done_a;
  logic [3:0]  mask_a;
  logic [15:0] cal_a [4];
  logic [7:0]  tx_data_a, ovf_a;
  logic [2:0]  st_a;

  // Instance B: DECIM=4, OVF_W=2
  logic        enable_b, sclk_b, tx_start_b, tx_busy_b, busy_b, done_b;
  logic [3:0]  mask_b;
  logic [7:0]  tx_data_b;
  logic [1:0]  ovf_b;
  logic [2:0]  st_b;

  sample_uart_scheduler #(.DECIM(1), .OVF_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .ch_mask(mask_a),
    .sample_clk(sclk_a), .cal_in0(cal_a[0]), .cal_in1(cal_a[1]),
    .cal_in2(cal_a[2]), .cal_in3(cal_a[3]), .tx_data(tx_data_a),
    .tx_start(tx_start_a), .tx_busy(tx_busy_a), .busy(busy_a),
    .frame_done(done_a), .overruns(ovf_a), .state_dbg(st_a)
  );

  sample_uart_scheduler #(.DECIM(4), .OVF_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .ch_mask(mask_b),
    .sample_clk(sclk_b), .cal_in0(16'h1111), .cal_in1(16'h2222),
    .cal_in2(16'h3333), .cal_in3(16'h4444), .tx_data(tx_data_b),
    .tx_start(tx_start_b), .tx_busy(tx_busy_b), .busy(busy_b),
    .frame_done(done_b), .overruns(ovf_b), .state_dbg(st_b)
  );

  // UART stubs: busy from the cycle after tx_start for blen cycles (0 = random 1..10)
  int unsigned blen_a = 10, blen_b = 2;
  int unsigned cnt_a, cnt_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_a <= 0;
    else if (tx_start_a) cnt_a <= (blen_a == 0) ? $urandom_range(1, 10) : blen_a;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_b <= 0;
    else if (tx_start_b) cnt_b <= blen_b;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  end
  assign tx_busy_a = (cnt_a != 0);
  assign tx_busy_b = (cnt_b != 0);

  int total = 0, bad = 0;
  int exp_ovf = 0;
  int n_tx_a = 0;
  logic [8:0] exp_q[$];   // bit 8 set = frame_done marker

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  // Monitor: every issued byte and every frame_done must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start_a) begin
        n_tx_a++;
        if (exp_q.size() == 0) fail_now("unexpected tx_start");
        else check("tx byte", {23'b0, 1'b0, tx_data_a}, {23'b0, exp_q.pop_front()});
      end
      if (done_a) begin
        if (exp_q.size() == 0) fail_now("unexpected frame_done");
        else check("frame_done", 32'h100, {23'b0, exp_q.pop_front()});
      end
    end
  end

  // Reference: a frame is the 5-byte record of each enabled channel, ascending
  task automatic push_frame(input logic [3:0] m);
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        exp_q.push_back({1'b0, 8'h43});
        exp_q.push_back({1'b0, 8'h48});
        exp_q.push_back({1'b0, 8'h30 + 8'(c)});
        exp_q.push_back({1'b0, cal_a[c][15:8]});
        exp_q.push_back({1'b0, cal_a[c][7:0]});
      end
    end
    exp_q.push_back(9'h100);
  endtask

  task automatic tick_a(input logic en, input logic [3:0] m, input bit in_frame);
    @(negedge clk);
    enable_a = en;
    mask_a   = m;
    sclk_a   = 1'b1;
    if (in_frame) begin
      if (exp_ovf < 255) exp_ovf++;
    end else if (en && m != 4'b0) begin
      push_frame(m);
    end
    @(negedge clk);
    sclk_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while ((busy_a || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("idle timeout");
  endtask

  task automatic rand_cal();
    for (int c = 0; c < 4; c++) cal_a[c] = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    int lat, base, n, rises, drops;
    rst_n = 1'b0;
    enable_a = 1'b1; mask_a = 4'h0; sclk_a = 1'b0;
    enable_b = 1'b1; mask_b = 4'h1; sclk_b = 1'b0;
    for (int c = 0; c < 4; c++) cal_a[c] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst tx_data", {24'b0, tx_data_a}, 32'h0);
    check("rst tx_start", {31'b0, tx_start_a}, 32'h0);
    check("rst busy", {31'b0, busy_a}, 32'h0);
    check("rst frame_done", {31'b0, done_a}, 32'h0);
    check("rst overruns", {24'b0, ovf_a}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed 4-channel frame plus tick-to-first-strobe latency
    cal_a[0] = 16'h1234; cal_a[1] = 16'hFFFF; cal_a[2] = 16'h8000; cal_a[3] = 16'h0001;
    blen_a = 10;
    @(negedge clk);
    enable_a = 1'b1; mask_a = 4'hF; sclk_a = 1'b1;
    push_frame(4'hF);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      sclk_a = 1'b0;
      if (tx_start_a) break;
    end
    check("first byte latency", 32'(lat), 32'd3);
    wait_idle_a(2000);
    check("ovf after frame1", {24'b0, ovf_a}, 32'h0);

    // Sparse mask, then an empty-mask tick that must be ignored
    blen_a = 0;
    rand_cal();
    tick_a(1'b1, 4'b1010, 1'b0);
    wait_idle_a(2000);
    tick_a(1'b1, 4'b0000, 1'b0);
    repeat (10) @(negedge clk);
    check("mask0 stays idle", {31'b0, busy_a}, 32'h0);
    check("mask0 no overrun", {24'b0, ovf_a}, 32'h0);

    // Randomized snapshots, masks and enables from idle
    for (int k = 0; k < 10; k++) begin
      rand_cal();
      tick_a(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'b0);
      wait_idle_a(2000);
    end

    // Five ticks dropped during one frame
    rand_cal();
    tick_a(1'b1, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      rand_cal();
      tick_a(1'b1, 4'($urandom_range(1, 15)), 1'b1);
    end
    wait_idle_a(2000);
    check("overruns after 5 drops", {24'b0, ovf_a}, 32'(exp_ovf));

    // Snapshot coherence and enable drop mid-frame
    cal_a[0] = 16'h1234;
    base = n_tx_a;
    tick_a(1'b1, 4'b0001, 1'b0);
    n = 0;
    while (n_tx_a < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("second byte timeout");
    cal_a[0] = 16'hAAAA;
    mask_a   = 4'hF;
    enable_a = 1'b0;
    wait_idle_a(2000);
    tick_a(1'b0, 4'hF, 1'b0);
    repeat (10) @(negedge clk);
    check("disabled tick ignored", {31'b0, busy_a}, 32'h0);
    check("disabled no overrun", {24'b0, ovf_a}, 32'(exp_ovf));

    // Reset while waiting for the UART to go busy
    tick_a(1'b1, 4'b1100, 1'b0);
    n = 0;
    while (!tx_start_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("tx_start timeout");
    check("in WBUSY before reset", {29'b0, st_a}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 0;
    check("mid rst tx_start", {31'b0, tx_start_a}, 32'h0);
    check("mid rst busy", {31'b0, busy_a}, 32'h0);
    check("mid rst overruns", {24'b0, ovf_a}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_cal();
    tick_a(1'b1, 4'b0110, 1'b0);
    wait_idle_a(2000);

    // Decimation by 4: only rises 1, 5, 9 start frames
    for (int r = 1; r <= 12; r++) begin
      @(negedge clk); sclk_b = 1'b1;
      @(negedge clk); sclk_b = 1'b0;
      check($sformatf("decim rise %0d", r), {31'b0, busy_b}, {31'b0, (r % 4) == 1});
      repeat (60) @(negedge clk);
    end

    // Saturation of a 2-bit overrun counter
    blen_b = 200;
    rises = 12;
    drops = 0;
    @(negedge clk); sclk_b = 1'b1;
    @(negedge clk); sclk_b = 1'b0;
    rises++;
    check("sat frame start", {31'b0, busy_b}, 32'h1);
    for (int r = 0; r < 24; r++) begin
      @(negedge clk); sclk_b = 1'b1;
      @(negedge clk); sclk_b = 1'b0;
      rises++;
      if (rises % 4 == 1) begin
        drops++;
        check($sformatf("sat ovf drop %0d", drops), {30'b0, ovf_b},
              32'((drops > 3) ? 3 : drops));
      end
    end
    n = 0;
    while (busy_b && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("B idle timeout");
    check("sat ovf final", {30'b0, ovf_b}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
